// File: rtl/cbc_decrypt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cbc_decrypt_sequencer_if
// Brief    : Stream and core-side signals of the CBC decryption sequencer.
//            Carries the ciphertext input stream, the plaintext output
//            stream and the launch/result handshake with the shared
//            AES-128 inverse-cipher core.
// Revision : 1.0 - initial release
// ============================================================================
interface cbc_decrypt_sequencer_if;
  // Ciphertext stream into the sequencer
  logic         ct_valid;
  logic         ct_ready;
  logic [0:127] ct_data;
  // Shared inverse-cipher core
  logic         core_start;
  logic [0:127] core_ct;
  logic         core_done;
  logic [0:127] core_pt;
  // Plaintext stream out of the sequencer
  logic         pt_valid;
  logic         pt_ready;
  logic [0:127] pt_data;
  logic         pt_last;

  // Sequencer side
  modport master (
    input  ct_valid, ct_data, core_done, core_pt, pt_ready,
    output ct_ready, core_start, core_ct, pt_valid, pt_data, pt_last
  );

  // Environment side: stream source/sink and the core itself
  modport slave (
    output ct_valid, ct_data, core_done, core_pt, pt_ready,
    input  ct_ready, core_start, core_ct, pt_valid, pt_data, pt_last
  );
endinterface
`default_nettype wire

// File: rtl/cbc_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cbc_decrypt_sequencer
// Brief    : Runs one CBC decryption message of NBLK 128-bit blocks through a
//            single time-shared, multi-cycle AES-128 inverse-cipher core and
//            XORs the chaining value onto each raw core result.
// Options  : CBC_CHAIN_CARRY_EN - a start with iv_keep=1 keeps the chaining
//            value, so the previous message's last ciphertext becomes the IV.
// Revision : 1.0 - initial release
// ============================================================================
module cbc_decrypt_sequencer #(
  parameter int NBLK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:127]           iv,
  input  logic                   iv_keep,
  output logic                   busy,
  output logic [$clog2(NBLK):0]  blk_idx,
  output logic                   done,
  cbc_decrypt_sequencer_if.master bus
);

  localparam int                IDX_W    = $clog2(NBLK) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBLK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [0:127] chain;    // IV, then the previous ciphertext block
  logic [0:127] cur_ct;   // block in flight; also what the core sees
  logic [0:127] pt_data;
  logic         pt_last;

  logic         ct_ready;
  logic         core_start;
  logic         pt_valid;

`ifndef CBC_CHAIN_CARRY_EN
  // iv_keep has no function without chain carry
  logic unused_iv_keep;
  assign unused_iv_keep = iv_keep;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_nxt  = state;
    ct_ready   = 1'b0;
    core_start = 1'b0;
    pt_valid   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        ct_ready = 1'b1;
        if (bus.ct_valid) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // core_done outside WAIT never reaches this branch, so stray pulses
        // after a reset are dropped here
        if (bus.core_done) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        pt_valid = 1'b1;
        if (bus.pt_ready) state_nxt = pt_last ? IDLE : FETCH;
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Datapath: chaining value, block capture, XOR result and block counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain   <= '0;
      cur_ct  <= '0;
      pt_data <= '0;
      pt_last <= 1'b0;
      blk_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef CBC_CHAIN_CARRY_EN
            if (!iv_keep) chain <= iv;
`else
            chain <= iv;
`endif
            blk_idx <= '0;
          end
        end
        FETCH: begin
          if (bus.ct_valid) cur_ct <= bus.ct_data;
        end
        WAIT: begin
          if (bus.core_done) begin
            pt_data <= bus.core_pt ^ chain;
            chain   <= cur_ct;
            pt_last <= (blk_idx == LAST_IDX);
          end
        end
        OUTPUT: begin
          if (bus.pt_ready) begin
            if (pt_last) begin
              done    <= 1'b1;
              blk_idx <= '0;
            end else begin
              blk_idx <= blk_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ct_ready   = ct_ready;
  assign bus.core_start = core_start;
  assign bus.core_ct    = cur_ct;
  assign bus.pt_valid   = pt_valid;
  assign bus.pt_data    = pt_data;
  assign bus.pt_last    = pt_last;

endmodule
`default_nettype wire

// File: tb/tb_cbc_decrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbc_decrypt_sequencer
// Brief    : Self-checking bench for cbc_decrypt_sequencer. An NBLK=8 instance
//            runs against an identity core (latency 3); an NBLK=1 instance
//            runs against a core stub that knows one AES-128 answer
//            (latency 2) and is identity otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbc_decrypt_sequencer;

  localparam logic [0:127] KAT_CT  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [0:127] KAT_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] KAT_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  // Raw AES-128 inverse cipher of KAT_CT under key 2b7e1516...: KAT_PT ^ KAT_IV
  localparam logic [0:127] KAT_RAW = 128'h6bc0bce12a459991e134741a7f9e1925;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- NBLK=8 instance, identity core, L=3 ----------------
  logic         start8 = 1'b0, iv_keep8 = 1'b0, busy8, done8;
  logic [0:127] iv8 = '0;
  logic [3:0]   idx8;
  cbc_decrypt_sequencer_if bus8 ();
  cbc_decrypt_sequencer #(.NBLK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .iv(iv8), .iv_keep(iv_keep8),
    .busy(busy8), .blk_idx(idx8), .done(done8), .bus(bus8)
  );
  logic [2:0] pipe8  = '0;
  int         starts8 = 0;
  always @(posedge clk) begin
    pipe8 <= {pipe8[1:0], bus8.core_start};
    if (bus8.core_start) starts8 <= starts8 + 1;
  end
  assign bus8.core_done = pipe8[2];
  assign bus8.core_pt   = bus8.core_ct;

  // ---------------- NBLK=1 instance, known-answer core, L=2 -------------
  logic         start1 = 1'b0, iv_keep1 = 1'b0, busy1, done1;
  logic [0:127] iv1 = '0;
  logic [0:0]   idx1;
  cbc_decrypt_sequencer_if bus1 ();
  cbc_decrypt_sequencer #(.NBLK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .iv(iv1), .iv_keep(iv_keep1),
    .busy(busy1), .blk_idx(idx1), .done(done1), .bus(bus1)
  );
  logic [1:0] pipe1 = '0;
  always @(posedge clk) pipe1 <= {pipe1[0], bus1.core_start};
  assign bus1.core_done = pipe1[1];
  assign bus1.core_pt   = (bus1.core_ct == KAT_CT) ? KAT_RAW : bus1.core_ct;

  // ---------------- reference model -------------------------------------
  logic [0:127] ct_mem [8];

  // CBC decryption with the identity core: pt_k = ct_k ^ (k==0 ? iv : ct_{k-1})
  function automatic logic [0:127] model_pt(input int k, input logic [0:127] ivv);
    return ct_mem[k] ^ ((k == 0) ? ivv : ct_mem[k-1]);
  endfunction

  // ---------------- observations captured by the message driver ---------
  logic [0:127] got_pt   [8];
  logic         got_last [8];
  logic [3:0]   got_idx  [8];
  logic [3:0]   got_fidx [8];
  int  hold_bad, fetch_bad, early_done, launches, msg_cycles;
  bit  timeout, done_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one NBLK=8 message; stall lengths per block, optional random
  // stalls, optional start pokes while busy, optional abort in WAIT.
  task automatic run8(input logic [0:127] ivv, input int cs_blk, input int cs_n,
                      input int ps_blk, input int ps_n, input bit rnd,
                      input bit poke, input int abort_blk);
    int n, s0, t0, ws;
    logic [0:127] held;
    timeout = 0; hold_bad = 0; fetch_bad = 0; early_done = 0; done_ok = 0;
    s0 = starts8;
    start8 = 1'b1; iv8 = ivv;
    step();
    start8 = 1'b0; t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!bus8.ct_ready && n < 40) begin step(); n++; end
      if (n >= 40) timeout = 1;
      ws = (k == cs_blk) ? cs_n : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < ws; s++) begin
        if (poke) begin start8 = 1'b1; iv8 = {$urandom, $urandom, $urandom, $urandom}; end
        step();
        if (!bus8.ct_ready || bus8.core_start) fetch_bad++;
      end
      start8 = 1'b0;
      got_fidx[k] = idx8;
      bus8.ct_valid = 1'b1; bus8.ct_data = ct_mem[k];
      step();
      bus8.ct_valid = 1'b0; bus8.ct_data = {$urandom, $urandom, $urandom, $urandom};
      if (k == abort_blk) begin
        step();  // now in WAIT with the core result still pending
        return;
      end
      n = 0;
      while (!bus8.pt_valid && n < 40) begin
        if (poke) start8 = 1'b1;
        step(); n++;
        if (done8) early_done++;
      end
      start8 = 1'b0;
      if (n >= 40) timeout = 1;
      got_pt[k] = bus8.pt_data; got_last[k] = bus8.pt_last; got_idx[k] = idx8;
      held = bus8.pt_data;
      ws = (k == ps_blk) ? ps_n : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < ws; s++) begin
        step();
        if (!bus8.pt_valid || bus8.pt_data !== held || bus8.pt_last !== got_last[k] ||
            bus8.ct_ready) hold_bad++;
      end
      bus8.pt_ready = 1'b1;
      step();
      bus8.pt_ready = 1'b0;
      if (k < 7 && done8) early_done++;
    end
    done_ok = done8 && !busy8;
    msg_cycles = cyc - t0;
    step();
    if (done8) done_ok = 0;
    launches = starts8 - s0;
  endtask

  // Drives one NBLK=1 message and returns what came out
  task automatic run1(input logic [0:127] ivv, input logic keep, input logic [0:127] ctv,
                      output logic [0:127] pt, output logic last, output logic dn,
                      output bit to);
    int n;
    to = 0;
    start1 = 1'b1; iv1 = ivv; iv_keep1 = keep;
    step();
    start1 = 1'b0;
    n = 0;
    while (!bus1.ct_ready && n < 20) begin step(); n++; end
    if (n >= 20) to = 1;
    bus1.ct_valid = 1'b1; bus1.ct_data = ctv;
    step();
    bus1.ct_valid = 1'b0;
    n = 0;
    while (!bus1.pt_valid && n < 20) begin step(); n++; end
    if (n >= 20) to = 1;
    pt = bus1.pt_data; last = bus1.pt_last;
    bus1.pt_ready = 1'b1;
    step();
    bus1.pt_ready = 1'b0;
    dn = done1 && !busy1;
  endtask

  // ---------------- tests -----------------------------------------------
  task automatic test_reset();
    step(); step();
    n_chk++;
    if ({busy8, done8, idx8, bus8.ct_ready, bus8.core_start, bus8.pt_valid, bus8.pt_last} !== '0 ||
        bus8.core_ct !== '0 || bus8.pt_data !== '0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b idx=%0d ct_ready=%b core_start=%b pt_valid=%b pt_last=%b core_ct=%h pt_data=%h, all required 0",
               busy8, done8, idx8, bus8.ct_ready, bus8.core_start, bus8.pt_valid, bus8.pt_last, bus8.core_ct, bus8.pt_data);
    end
    n_chk++;
    if ({busy1, done1, idx1, bus1.ct_ready, bus1.core_start, bus1.pt_valid, bus1.pt_last} !== '0 ||
        bus1.core_ct !== '0 || bus1.pt_data !== '0) begin
      n_fail++;
      $display("FAIL reset1: busy=%b done=%b pt_valid=%b pt_data=%h, all required 0",
               busy1, done1, bus1.pt_valid, bus1.pt_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_kat();
    logic [0:127] pt; logic last, dn; bit to;
    run1(KAT_IV, 1'b0, KAT_CT, pt, last, dn, to);
    n_chk++;
    if (to || pt !== KAT_PT) begin
      n_fail++; $display("FAIL kat_pt: got %h timeout=%0d, expected %h", pt, to, KAT_PT);
    end
    n_chk++;
    if ({last, dn} !== 2'b11) begin
      n_fail++; $display("FAIL kat_last_done: got last=%b done=%b, expected 1 1", last, dn);
    end
  endtask

  task automatic test_identity8();
    for (int k = 0; k < 8; k++) ct_mem[k] = {16{8'(k)}};
    run8('0, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (got_pt[k] !== model_pt(k, '0)) begin
        n_fail++; $display("FAIL ident_pt[%0d]: got %h expected %h", k, got_pt[k], model_pt(k, '0));
      end
      n_chk++;
      if ({got_last[k], got_idx[k], got_fidx[k]} !== {(k == 7), 4'(k), 4'(k)}) begin
        n_fail++; $display("FAIL ident_idx[%0d]: got last=%b idx=%0d/%0d expected last=%b idx=%0d",
                           k, got_last[k], got_fidx[k], got_idx[k], (k == 7), k);
      end
    end
    // the sample right after the accept edge is cycle 1 of the message
    n_chk++;
    if (timeout || !done_ok || msg_cycles + 1 !== 8 * (3 + 3) + 1) begin
      n_fail++; $display("FAIL ident_timing: got start-to-done %0d done_ok=%0d timeout=%0d, expected 49 1 0",
                         msg_cycles + 1, done_ok, timeout);
    end
  endtask

  task automatic test_random();
    logic [0:127] ivv;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 8; k++) ct_mem[k] = {$urandom, $urandom, $urandom, $urandom};
      ivv = {$urandom, $urandom, $urandom, $urandom};
      run8(ivv, -1, 0, -1, 0, 1'b1, 1'b0, -1);
      for (int k = 0; k < 8; k++) begin
        n_chk++;
        if (got_pt[k] !== model_pt(k, ivv) || got_last[k] !== (k == 7)) begin
          n_fail++; $display("FAIL rand%0d_pt[%0d]: got %h last=%b expected %h last=%b",
                             m, k, got_pt[k], got_last[k], model_pt(k, ivv), (k == 7));
        end
      end
      n_chk++;
      if (timeout || !done_ok || early_done != 0 || launches != 8) begin
        n_fail++; $display("FAIL rand%0d_ctl: got timeout=%0d done_ok=%0d early_done=%0d launches=%0d expected 0 1 0 8",
                           m, timeout, done_ok, early_done, launches);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] ivv;
    for (int k = 0; k < 8; k++) ct_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    ivv = {$urandom, $urandom, $urandom, $urandom};
    run8(ivv, 3, 6, 2, 10, 1'b0, 1'b0, -1);
    n_chk++;
    if (hold_bad != 0 || fetch_bad != 0 || launches != 8) begin
      n_fail++; $display("FAIL bp_hold: got hold_bad=%0d fetch_bad=%0d launches=%0d expected 0 0 8",
                         hold_bad, fetch_bad, launches);
    end
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (got_pt[k] !== model_pt(k, ivv)) begin
        n_fail++; $display("FAIL bp_pt[%0d]: got %h expected %h", k, got_pt[k], model_pt(k, ivv));
      end
    end
    n_chk++;
    if (timeout || !done_ok) begin
      n_fail++; $display("FAIL bp_done: got timeout=%0d done_ok=%0d expected 0 1", timeout, done_ok);
    end
  endtask

  task automatic test_start_during_busy();
    logic [0:127] ivv;
    for (int k = 0; k < 8; k++) ct_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    ivv = {$urandom, $urandom, $urandom, $urandom};
    run8(ivv, 1, 3, 5, 2, 1'b1, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (got_pt[k] !== model_pt(k, ivv) || got_idx[k] !== 4'(k)) begin
        n_fail++; $display("FAIL busy_start_pt[%0d]: got %h idx=%0d expected %h idx=%0d",
                           k, got_pt[k], got_idx[k], model_pt(k, ivv), k);
      end
    end
    n_chk++;
    if (timeout || !done_ok || launches != 8 || busy8) begin
      n_fail++; $display("FAIL busy_start_ctl: got timeout=%0d done_ok=%0d launches=%0d busy=%b expected 0 1 8 0",
                         timeout, done_ok, launches, busy8);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:127] ivv;
    int bad;
    for (int k = 0; k < 8; k++) ct_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    ivv = {$urandom, $urandom, $urandom, $urandom};
    run8(ivv, -1, 0, -1, 0, 1'b0, 1'b0, 4);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy8, done8, idx8, bus8.ct_ready, bus8.core_start, bus8.pt_valid, bus8.pt_last} !== '0 ||
        bus8.core_ct !== '0 || bus8.pt_data !== '0) begin
      n_fail++; $display("FAIL rst_mid_zero: busy=%b idx=%0d pt_valid=%b core_ct=%h pt_data=%h, all required 0",
                         busy8, idx8, bus8.pt_valid, bus8.core_ct, bus8.pt_data);
    end
    step();
    rst = 1'b0;
    bad = 0;
    // the pending core result arrives during these cycles and must be dropped
    for (int s = 0; s < 5; s++) begin
      step();
      if (busy8 || bus8.pt_valid || bus8.pt_data !== '0 || done8 || bus8.ct_ready) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_mid_stray: got %0d disturbed cycles, expected 0", bad);
    end
    for (int k = 0; k < 8; k++) ct_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    ivv = {$urandom, $urandom, $urandom, $urandom};
    run8(ivv, -1, 0, -1, 0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (got_pt[k] !== model_pt(k, ivv) || got_fidx[k] !== 4'(k)) begin
        n_fail++; $display("FAIL rst_mid_rerun[%0d]: got %h idx=%0d expected %h idx=%0d",
                           k, got_pt[k], got_fidx[k], model_pt(k, ivv), k);
      end
    end
  endtask

  // Runs directly after a reset, so the carried chaining value starts at 0
  task automatic test_chain_carry();
    logic [0:127] pt, ct_a, ct_b, ct_c, iv_c, exp; logic last, dn; bit to;
    ct_a = {$urandom, $urandom, $urandom, $urandom};
    run1('1, 1'b1, ct_a, pt, last, dn, to);
`ifdef CBC_CHAIN_CARRY_EN
    exp = ct_a;
`else
    exp = ct_a ^ {128{1'b1}};
`endif
    n_chk++;
    if (to || !dn || pt !== exp) begin
      n_fail++; $display("FAIL chain_after_reset: got %h done=%b timeout=%0d expected %h", pt, dn, to, exp);
    end
    ct_b = {$urandom, $urandom, $urandom, $urandom};
    run1('1, 1'b1, ct_b, pt, last, dn, to);
`ifdef CBC_CHAIN_CARRY_EN
    exp = ct_b ^ ct_a;
`else
    exp = ct_b ^ {128{1'b1}};
`endif
    n_chk++;
    if (to || !dn || pt !== exp) begin
      n_fail++; $display("FAIL chain_keep: got %h done=%b timeout=%0d expected %h", pt, dn, to, exp);
    end
    ct_c = {$urandom, $urandom, $urandom, $urandom};
    iv_c = {$urandom, $urandom, $urandom, $urandom};
    run1(iv_c, 1'b0, ct_c, pt, last, dn, to);
    n_chk++;
    if (to || !dn || pt !== (ct_c ^ iv_c)) begin
      n_fail++; $display("FAIL chain_load: got %h done=%b timeout=%0d expected %h", pt, dn, to, ct_c ^ iv_c);
    end
  endtask

  initial begin
    bus8.ct_valid = 1'b0; bus8.ct_data = '0; bus8.pt_ready = 1'b0;
    bus1.ct_valid = 1'b0; bus1.ct_data = '0; bus1.pt_ready = 1'b0;
    test_reset();
    test_kat();
    test_identity8();
    test_random();
    test_backpressure();
    test_start_during_busy();
    test_reset_mid();
    test_chain_carry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
